// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS core: sequences the shared ALU,
// the shared memory port and the register file, and decodes every datapath
// strobe from the current state (FETCH also gates its PC/IR loads on ready).
module multicycle_control #(
  parameter bit MEM_WAIT_EN  = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_con_Opcode,
  input  logic       i_con_Zero,
  input  logic       i_con_MemReady,
  output logic       o_con_PCWrite,
  output logic       o_con_PCWriteCond,
  output logic       o_con_IorD,
  output logic       o_con_MemRead,
  output logic       o_con_MemWrite,
  output logic       o_con_IRWrite,
  output logic       o_con_MemtoReg,
  output logic       o_con_RegDst,
  output logic       o_con_RegWrite,
  output logic       o_con_AluSrcA,
  output logic [1:0] o_con_AluSrcB,
  output logic [1:0] o_con_AluOp,
  output logic [3:0] o_con_Other,
  output logic [1:0] o_con_PCSource,
  output logic       o_con_ZeroExt,
  output logic       o_con_Illegal,
  output logic [3:0] o_con_State
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t state_q, state_d;
  logic   mem_rdy;

  // The branch comparison is resolved in the datapath through PCWriteCond,
  // so the zero flag is not needed by the sequencer itself.
  logic   unused_zero;
  assign unused_zero = i_con_Zero;

  // With waiting disabled every memory access completes in one cycle.
  assign mem_rdy = MEM_WAIT_EN ? i_con_MemReady : 1'b1;

  // Immediate-op code handed to alu_control for the I-type ALU group.
  function automatic logic [3:0] imm_other(input logic [5:0] op);
    case (op)
      6'd12:   imm_other = 4'd1;
      6'd13:   imm_other = 4'd2;
      6'd14:   imm_other = 4'd3;
      6'd10,
      6'd11:   imm_other = 4'd6;
      default: imm_other = 4'd0;
    endcase
  endfunction

  // State register; reset returns to IDLE so every strobe drops at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state sequencing, including memory stalls and opcode dispatch.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_con_Opcode)
          OP_RTYPE: state_d = S_REXEC;
          OP_J:     state_d = S_JUMP;
          OP_BEQ:   state_d = S_BRANCH;
          6'd8, 6'd9, 6'd10, 6'd11,
          6'd12, 6'd13, 6'd14: state_d = S_IEXEC;
          OP_LW, OP_SW:        state_d = S_MEMADR;
          default:  state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (i_con_Opcode == OP_LW)      state_d = S_MEMRD;
        else if (i_con_Opcode == OP_SW) state_d = S_MEMWR;
        else                            state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    o_con_PCWrite     = 1'b0;
    o_con_PCWriteCond = 1'b0;
    o_con_IorD        = 1'b0;
    o_con_MemRead     = 1'b0;
    o_con_MemWrite    = 1'b0;
    o_con_IRWrite     = 1'b0;
    o_con_MemtoReg    = 1'b0;
    o_con_RegDst      = 1'b0;
    o_con_RegWrite    = 1'b0;
    o_con_AluSrcA     = 1'b0;
    o_con_AluSrcB     = 2'd0;
    o_con_AluOp       = 2'b00;
    o_con_Other       = 4'd0;
    o_con_PCSource    = 2'd0;
    o_con_ZeroExt     = 1'b0;
    o_con_Illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_con_MemRead = 1'b1;
        o_con_AluSrcB = 2'd1;
        o_con_PCWrite = mem_rdy;
        o_con_IRWrite = mem_rdy;
      end
      S_DECODE: o_con_AluSrcB = 2'd3;
      S_MEMADR: begin
        o_con_AluSrcA = 1'b1;
        o_con_AluSrcB = 2'd2;
      end
      S_MEMRD: begin
        o_con_MemRead = 1'b1;
        o_con_IorD    = 1'b1;
      end
      S_MEMWB: begin
        o_con_RegWrite = 1'b1;
        o_con_MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        o_con_MemWrite = 1'b1;
        o_con_IorD     = 1'b1;
      end
      S_REXEC: begin
        o_con_AluSrcA = 1'b1;
        o_con_AluOp   = 2'b10;
      end
      S_RWB: begin
        o_con_RegWrite = 1'b1;
        o_con_RegDst   = 1'b1;
      end
      S_BRANCH: begin
        o_con_AluSrcA     = 1'b1;
        o_con_AluOp       = 2'b01;
        o_con_PCWriteCond = 1'b1;
        o_con_PCSource    = 2'd1;
      end
      S_IEXEC: begin
        o_con_AluSrcA = 1'b1;
        o_con_AluSrcB = 2'd2;
        o_con_AluOp   = 2'b11;
        o_con_Other   = imm_other(i_con_Opcode);
        o_con_ZeroExt = (i_con_Opcode >= 6'd12) && (i_con_Opcode <= 6'd14);
      end
      // ALU controls stay as in IEXEC so alu_control sees a steady op.
      S_IWB: begin
        o_con_RegWrite = 1'b1;
        o_con_AluOp    = 2'b11;
        o_con_Other    = imm_other(i_con_Opcode);
        o_con_ZeroExt  = (i_con_Opcode >= 6'd12) && (i_con_Opcode <= 6'd14);
      end
      S_JUMP: begin
        o_con_PCWrite  = 1'b1;
        o_con_PCSource = 2'd2;
      end
      S_TRAP:  o_con_Illegal = 1'b1;
      default: ;
    endcase
  end

  assign o_con_State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the
// control word expected for that cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop;
    logic [3:0] other;
    logic [1:0] pcsrc;
    logic       zext, ill;
    logic [3:0] st;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       ready = 1'b1;

  logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, zext, ill;
  logic [1:0] srcb, aluop, pcsrc;
  logic [3:0] other, st;
  ctl_t       obs;

  int n_chk = 0;
  int n_fail = 0;
  ctl_t exp_q[$];

  multicycle_control #(.MEM_WAIT_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_con_Opcode(opcode), .i_con_Zero(zero),
    .i_con_MemReady(ready),
    .o_con_PCWrite(pcw), .o_con_PCWriteCond(pcwc), .o_con_IorD(iord),
    .o_con_MemRead(mrd), .o_con_MemWrite(mwr), .o_con_IRWrite(irw),
    .o_con_MemtoReg(m2r), .o_con_RegDst(rdst), .o_con_RegWrite(rw),
    .o_con_AluSrcA(srca), .o_con_AluSrcB(srcb), .o_con_AluOp(aluop),
    .o_con_Other(other), .o_con_PCSource(pcsrc), .o_con_ZeroExt(zext),
    .o_con_Illegal(ill), .o_con_State(st)
  );

  assign obs = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                srcb, aluop, other, pcsrc, zext, ill, st};

  always #5 clk = ~clk;

  task automatic check(input string tag, input ctl_t got, input ctl_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
               tag, got, exp, got.st, exp.st);
    end
  endtask

  // Expected control words, one per state.
  function automatic ctl_t c_idle();
    ctl_t c = '0;
    return c;
  endfunction
  function automatic ctl_t c_fetch(input logic r);
    ctl_t c = '0;
    c.st = 4'd1; c.mrd = 1'b1; c.srcb = 2'd1; c.pcw = r; c.irw = r;
    return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.st = 4'd2; c.srcb = 2'd3;
    return c;
  endfunction
  function automatic ctl_t c_memadr();
    ctl_t c = '0;
    c.st = 4'd3; c.srca = 1'b1; c.srcb = 2'd2;
    return c;
  endfunction
  function automatic ctl_t c_memrd();
    ctl_t c = '0;
    c.st = 4'd4; c.mrd = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c = '0;
    c.st = 4'd5; c.rw = 1'b1; c.m2r = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwr();
    ctl_t c = '0;
    c.st = 4'd6; c.mwr = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_rexec();
    ctl_t c = '0;
    c.st = 4'd7; c.srca = 1'b1; c.aluop = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_rwb();
    ctl_t c = '0;
    c.st = 4'd8; c.rw = 1'b1; c.rdst = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_branch();
    ctl_t c = '0;
    c.st = 4'd9; c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'd1;
    return c;
  endfunction
  function automatic ctl_t c_iexec(input logic [3:0] o, input logic z);
    ctl_t c = '0;
    c.st = 4'd10; c.srca = 1'b1; c.srcb = 2'd2; c.aluop = 2'b11;
    c.other = o; c.zext = z;
    return c;
  endfunction
  function automatic ctl_t c_iwb(input logic [3:0] o, input logic z);
    ctl_t c = '0;
    c.st = 4'd11; c.rw = 1'b1; c.aluop = 2'b11; c.other = o; c.zext = z;
    return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.st = 4'd12; c.pcw = 1'b1; c.pcsrc = 2'd2;
    return c;
  endfunction
  function automatic ctl_t c_trap();
    ctl_t c = '0;
    c.st = 4'd13; c.ill = 1'b1;
    return c;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue the
  // control word the DUT must present for the rest of that cycle.
  task automatic step(input logic [5:0] op, input logic rdy, input ctl_t e);
    @(posedge clk);
    #1;
    opcode = op;
    ready  = rdy;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check($sformatf("cyc_st%0d", st), obs, exp_q.pop_front());
  end

  initial begin
    // Reset held: everything idle.
    repeat (2) @(negedge clk);
    check("reset_hold", obs, c_idle());
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(c_idle());

    // R-type add, with one FETCH stall cycle first.
    step(6'd0, 1'b0, c_fetch(1'b0));
    step(6'd0, 1'b1, c_fetch(1'b1));
    step(6'd0, 1'b1, c_decode());
    step(6'd0, 1'b1, c_rexec());
    step(6'd0, 1'b1, c_rwb());

    // lw with two wait cycles in MEMRD.
    step(6'd35, 1'b1, c_fetch(1'b1));
    step(6'd35, 1'b1, c_decode());
    step(6'd35, 1'b1, c_memadr());
    step(6'd35, 1'b0, c_memrd());
    step(6'd35, 1'b0, c_memrd());
    step(6'd35, 1'b1, c_memrd());
    step(6'd35, 1'b1, c_memwb());

    // ori then slti.
    step(6'd13, 1'b1, c_fetch(1'b1));
    step(6'd13, 1'b1, c_decode());
    step(6'd13, 1'b1, c_iexec(4'd2, 1'b1));
    step(6'd13, 1'b1, c_iwb(4'd2, 1'b1));
    step(6'd10, 1'b1, c_fetch(1'b1));
    step(6'd10, 1'b1, c_decode());
    step(6'd10, 1'b1, c_iexec(4'd6, 1'b0));
    step(6'd10, 1'b1, c_iwb(4'd6, 1'b0));

    // beq with Zero=1, then j.
    zero = 1'b1;
    step(6'd4, 1'b1, c_fetch(1'b1));
    step(6'd4, 1'b1, c_decode());
    step(6'd4, 1'b1, c_branch());
    step(6'd2, 1'b1, c_fetch(1'b1));
    step(6'd2, 1'b1, c_decode());
    step(6'd2, 1'b1, c_jump());
    zero = 1'b0;

    // Illegal opcode: one TRAP cycle, then FETCH with Illegal low.
    step(6'd63, 1'b1, c_fetch(1'b1));
    step(6'd63, 1'b1, c_decode());
    step(6'd63, 1'b1, c_trap());

    // sw: stall in MEMWR, then reset mid-access.
    step(6'd43, 1'b1, c_fetch(1'b1));
    step(6'd43, 1'b1, c_decode());
    step(6'd43, 1'b1, c_memadr());
    step(6'd43, 1'b0, c_memwr());
    step(6'd43, 1'b0, c_memwr());
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_reset", obs, c_idle());
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(c_idle());

    // addi after reset, then a zero-wait sw to confirm normal operation.
    step(6'd8, 1'b1, c_fetch(1'b1));
    step(6'd8, 1'b1, c_decode());
    step(6'd8, 1'b1, c_iexec(4'd0, 1'b0));
    step(6'd8, 1'b1, c_iwb(4'd0, 1'b0));
    step(6'd43, 1'b1, c_fetch(1'b1));
    step(6'd43, 1'b1, c_decode());
    step(6'd43, 1'b1, c_memadr());
    step(6'd43, 1'b1, c_memwr());
    step(6'd0, 1'b1, c_fetch(1'b1));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS core. It sequences one shared ALU, one shared memory port and the register file across fetch/decode/execute/memory/writeback steps. It drives the 2-bit ALU op and 4-bit immediate-op code consumed by alu_control, plus all datapath mux and enable strobes. The FSM stalls on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1: memory states hold until i_con_MemReady=1; 0: i_con_MemReady ignored (treated as 1)
ILLEGAL_TRAP, 1, 1: unknown opcode pulses o_con_Illegal; 0: unknown opcode treated as NOP

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_con_Opcode  input  6  instruction[31:26] from IR (valid from DECODE onward)
i_con_Zero  input  1  ALU zero flag
i_con_MemReady  input  1  memory access complete this cycle
o_con_PCWrite  output  1  unconditional PC load
o_con_PCWriteCond  output  1  PC load if i_con_Zero
o_con_IorD  output  1  0=PC, 1=ALUOut as memory address
o_con_MemRead  output  1  memory read request
o_con_MemWrite  output  1  memory write request
o_con_IRWrite  output  1  IR load
o_con_MemtoReg  output  1  writeback source: 0=ALUOut, 1=MDR
o_con_RegDst  output  1  0=rt, 1=rd
o_con_RegWrite  output  1  register file write
o_con_AluSrcA  output  1  0=PC, 1=rs
o_con_AluSrcB  output  2  0=rt, 1=const 4, 2=sign/zero-ext imm, 3=imm<<2
o_con_AluOp  output  2  to alu_control: 00 add, 01 sub, 10 R-funct, 11 immediate
o_con_Other  output  4  immediate-op code to alu_control
o_con_PCSource  output  2  0=ALU, 1=ALUOut, 2=jump target
o_con_ZeroExt  output  1  1 = zero-extend immediate (andi/ori/xori)
o_con_Illegal  output  1  one-cycle pulse on unknown opcode
o_con_State  output  4  current state encoding, for debug

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BRANCH=9, IEXEC=10, IWB=11, JUMP=12, TRAP=13. Codes 14-15 are unreachable; if entered, go to IDLE.
- Reset (i_rst_n=0, async): state=IDLE and every output 0. In IDLE all outputs are 0. IDLE always goes to FETCH on the next edge.
- Outputs are decoded from the current state. Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=1, AluOp=00. PCWrite=IRWrite=MemReady, gated combinationally. Hold FETCH while MemReady=0; go to DECODE when 1.
- DECODE: AluSrcA=0, AluSrcB=3, AluOp=00 (branch target to ALUOut). Next state by opcode:
  - 0 -> REXEC
  - 2 -> JUMP
  - 4 -> BRANCH
  - 8, 9, 10, 11, 12, 13, 14 -> IEXEC
  - 35, 43 -> MEMADR
  - anything else -> TRAP (ILLEGAL_TRAP=1) or FETCH (ILLEGAL_TRAP=0)
- MEMADR: AluSrcA=1, AluSrcB=2, AluOp=00. Next is MEMRD if opcode=35, MEMWR if opcode=43.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady, then FETCH.
- REXEC: AluSrcA=1, AluSrcB=0, AluOp=10. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: AluSrcA=1, AluSrcB=0, AluOp=01, PCWriteCond=1, PCSource=1. Next FETCH.
- IEXEC: AluSrcA=1, AluSrcB=2, AluOp=11. o_con_Other mapping:
  - addi/addiu (8, 9) -> 0
  - andi (12) -> 1
  - ori (13) -> 2
  - xori (14) -> 3
  - slti/sltiu (10, 11) -> 6
  - ZeroExt=1 for opcodes 12-14.
  - Next IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Hold IEXEC's AluOp/Other/ZeroExt values (ALUOut already latched). Next FETCH.
- JUMP: PCWrite=1, PCSource=2. Next FETCH.
- TRAP: Illegal=1 for exactly this one cycle. Next FETCH. The PC is not modified.
- o_con_Other=0 in every state except IEXEC and IWB.
- The opcode is sampled only in DECODE, MEMADR, IEXEC and IWB. It is held stable by the IR, which is written only in FETCH.
- Latency, zero-wait memory:
  - R-type, immediate: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, j, trap: 3 cycles
  - Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds 1 cycle.
- Reset asserted mid-instruction: immediate return to IDLE, all strobes drop asynchronously, no partial RegWrite/MemWrite. After release, the next edge enters FETCH.

Test Plan:
- Reset: hold i_rst_n=0 -> all outputs 0, o_con_State=0. Release -> next edge State=1, MemRead=1, AluSrcB=1.
- R-type add, MemReady=1: opcode 0 -> State sequence 1,2,7,8,1. In REXEC AluOp=10. In RWB RegWrite=1, RegDst=1.
- lw with two wait cycles in MEMRD: opcode 35 -> sequence 1,2,3,4,4,4,5,1. MemRead=1 and IorD=1 for 3 cycles. MemtoReg=1 in MEMWB.
- ori: opcode 13 -> IEXEC shows AluOp=11, Other=2, ZeroExt=1. IWB RegWrite=1, RegDst=0. Repeat for slti (10) -> Other=6, ZeroExt=0.
- beq with Zero=1, then j: opcode 4 -> BRANCH shows AluOp=01, PCWriteCond=1, PCSource=1. Opcode 2 -> JUMP shows PCWrite=1, PCSource=2.
- Illegal opcode 63 and mid-operation reset: opcode 63 -> TRAP, Illegal high exactly 1 cycle, then FETCH. Assert reset during MEMWR with MemReady=0 -> MemWrite drops immediately, State=0.
